// File: rtl/game_flow_controller.sv
// Game flow sequencer for a single-ball game: arm, launch, pause, ball loss
// with a frozen delay, lives accounting and game over / restart.
module game_flow_controller #(
  parameter int unsigned LIVES             = 3,
  parameter int          LOST_Y            = 460,
  parameter int unsigned LOST_DELAY_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyLaunch,
  input  logic               keyPause,
  input  logic signed [10:0] ballTopLeftY,
  output logic               ballResetN,
  output logic               launch,
  output logic               pause,
  output logic [1:0]         livesLeft,
  output logic               gameOver,
  output logic [2:0]         state
);

  localparam int unsigned LIVES_W = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic signed [10:0] LOST_Y_S   = 11'(LOST_Y);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [CNT_W-1:0]   DELAY_INIT = CNT_W'(LOST_DELAY_FRAMES);

  typedef enum logic [STATE_W-1:0] {
    S_ARMED     = 3'd0,
    S_PLAYING   = 3'd1,
    S_PAUSED    = 3'd2,
    S_BALL_LOST = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               launch_q, launch_d;
  logic               pause_q, pause_d;
  logic               game_over_q, game_over_d;
  logic               ball_reset_n_q, ball_reset_n_d;

  logic key_launch_prev, key_pause_prev;
  logic hist_valid;
  logic launch_edge, pause_edge;
  logic ball_lost;

  // Key history; the first cycle after reset only primes it so held keys stay silent.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_launch_prev <= 1'b0;
      key_pause_prev  <= 1'b0;
      hist_valid      <= 1'b0;
    end else begin
      key_launch_prev <= keyLaunch;
      key_pause_prev  <= keyPause;
      hist_valid      <= 1'b1;
    end
  end

  assign launch_edge = hist_valid & keyLaunch & ~key_launch_prev;
  assign pause_edge  = hist_valid & keyPause  & ~key_pause_prev;
  assign ball_lost   = startOfFrame && (ballTopLeftY >= LOST_Y_S);

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_ARMED;
      lives_q        <= LIVES_INIT;
      frame_cnt_q    <= '0;
      launch_q       <= 1'b0;
      pause_q        <= 1'b0;
      game_over_q    <= 1'b0;
      ball_reset_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      frame_cnt_q    <= frame_cnt_d;
      launch_q       <= launch_d;
      pause_q        <= pause_d;
      game_over_q    <= game_over_d;
      ball_reset_n_q <= ball_reset_n_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    frame_cnt_d    = frame_cnt_q;
    launch_d       = 1'b0;
    ball_reset_n_d = 1'b1;

    case (state_q)
      S_ARMED: begin
        if (launch_edge) begin
          state_d  = S_PLAYING;
          launch_d = 1'b1;
        end
      end
      S_PLAYING: begin
        // A pause request takes priority; the loss is re-checked after resume.
        if (pause_edge) begin
          state_d = S_PAUSED;
        end else if (ball_lost) begin
          state_d     = S_BALL_LOST;
          lives_d     = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
          frame_cnt_d = DELAY_INIT;
        end
      end
      S_PAUSED: begin
        if (pause_edge) begin
          state_d = S_PLAYING;
        end
      end
      S_BALL_LOST: begin
        if (startOfFrame) begin
          if (frame_cnt_q <= CNT_W'(1)) begin
            frame_cnt_d = '0;
            if (lives_q == '0) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d        = S_ARMED;
              ball_reset_n_d = 1'b0;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - CNT_W'(1);
          end
        end
      end
      S_GAME_OVER: begin
        if (launch_edge) begin
          state_d        = S_ARMED;
          lives_d        = LIVES_INIT;
          ball_reset_n_d = 1'b0;
        end
      end
      default: begin
        state_d = S_ARMED;
      end
    endcase

    pause_d     = (state_d == S_PAUSED) || (state_d == S_BALL_LOST) ||
                  (state_d == S_GAME_OVER);
    game_over_d = (state_d == S_GAME_OVER);
  end

  assign state      = state_q;
  assign livesLeft  = lives_q;
  assign launch     = launch_q;
  assign pause      = pause_q;
  assign gameOver   = game_over_q;
  assign ballResetN = ball_reset_n_q;

endmodule
